// File: rtl/pll_lock_monitor_if.sv
// Status/control bundle between the PLL lock monitor and its host.
// The PLL side drives lock_raw and clear; the monitor drives the rest.
interface pll_lock_monitor_if #(
  parameter int CNT_W = 8
);
  logic             lock_raw;
  logic             clear;
  logic             locked;
  logic             pll_areset;
  logic             loss_sticky;
  logic [CNT_W-1:0] loss_count;
  logic [CNT_W-1:0] retry_count;

  modport master (
    output lock_raw,
    output clear,
    input  locked,
    input  pll_areset,
    input  loss_sticky,
    input  loss_count,
    input  retry_count
  );

  modport slave (
    input  lock_raw,
    input  clear,
    output locked,
    output pll_areset,
    output loss_sticky,
    output loss_count,
    output retry_count
  );
endinterface

// File: rtl/pll_lock_monitor.sv
// Qualifies raw PLL lock on the reference clock: glitch filter,
// stable-lock qualify, loss holdoff, areset retry and event counters.
module pll_lock_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int QUAL_CYCLES    = 1024,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int ARESET_CYCLES  = 16,
  parameter int CNT_W          = 8
) (
  input logic               clk,
  input logic               res,
  pll_lock_monitor_if.slave bus
);

  localparam int M1 = (QUAL_CYCLES > HOLDOFF_CYCLES) ?
                      QUAL_CYCLES : HOLDOFF_CYCLES;
  localparam int M2 = (TIMEOUT_CYCLES > ARESET_CYCLES) ?
                      TIMEOUT_CYCLES : ARESET_CYCLES;
  localparam int MX = (M1 > M2) ? M1 : M2;
  localparam int TW = (MX > 1) ? $clog2(MX) : 1;

  localparam logic [TW-1:0] T_QUAL = TW'(QUAL_CYCLES - 1);
  localparam logic [TW-1:0] T_HOLD = TW'(HOLDOFF_CYCLES - 1);
  localparam logic [TW-1:0] T_TO   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ARE  = TW'(ARESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_WAIT,
    S_QUAL,
    S_LOCKED,
    S_HOLDOFF,
    S_ARESET
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q;
  logic             timer_inc;
  logic             loss_ev, retry_ev;
  logic             lock_s;
  logic [SYNC_STAGES-1:0] sync_q;

  logic             locked_q, areset_q, sticky_q;
  logic             locked_d, areset_d, sticky_d;
  logic [CNT_W-1:0] loss_q, retry_q, loss_d, retry_d;

  // lock_raw is asynchronous; only the last stage is ever used
  always_ff @(posedge clk or posedge res) begin
    if (res) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.lock_raw};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_WAIT;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) timer_q <= '0;
      else if (timer_inc)     timer_q <= timer_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_inc = 1'b0;
    loss_ev   = 1'b0;
    retry_ev  = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (lock_s) state_d = S_QUAL;
        else if (timer_q == T_TO) begin
          state_d  = S_ARESET;
          retry_ev = 1'b1;
        end else timer_inc = 1'b1;
      end
      S_QUAL: begin
        if (!lock_s) state_d = S_WAIT;
        else if (timer_q == T_QUAL) state_d = S_LOCKED;
        else timer_inc = 1'b1;
      end
      S_LOCKED: begin
        if (!lock_s) begin
          state_d = S_HOLDOFF;
          loss_ev = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (timer_q == T_HOLD) state_d = S_WAIT;
        else timer_inc = 1'b1;
      end
      S_ARESET: begin
        if (timer_q == T_ARE) state_d = S_WAIT;
        else timer_inc = 1'b1;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // A clear on the same edge as an event keeps that one event
  always_comb begin
    locked_d = (state_d == S_LOCKED);
    areset_d = (state_d == S_ARESET);
    sticky_d = sticky_q | loss_ev;
    loss_d   = loss_q;
    retry_d  = retry_q;
    if (loss_ev && !(&loss_q))  loss_d  = loss_q + ONE;
    if (retry_ev && !(&retry_q)) retry_d = retry_q + ONE;
    if (bus.clear) begin
      sticky_d = loss_ev;
      loss_d   = loss_ev ? ONE : '0;
      retry_d  = retry_ev ? ONE : '0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      locked_q <= 1'b0;
      areset_q <= 1'b0;
      sticky_q <= 1'b0;
      loss_q   <= '0;
      retry_q  <= '0;
    end else begin
      locked_q <= locked_d;
      areset_q <= areset_d;
      sticky_q <= sticky_d;
      loss_q   <= loss_d;
      retry_q  <= retry_d;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.pll_areset  = areset_q;
  assign bus.loss_sticky = sticky_q;
  assign bus.loss_count  = loss_q;
  assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: directed scenarios plus random lock
// patterns, checked against a timestamp-based reference model.
module tb_pll_lock_monitor;

  localparam int QC  = 8;
  localparam int HC  = 4;
  localparam int TC  = 32;
  localparam int AC  = 3;
  localparam int CW  = 4;
  localparam int SAT = 15;

  localparam int P_WAIT = 0;
  localparam int P_QUAL = 1;
  localparam int P_LOCK = 2;
  localparam int P_HOLD = 3;
  localparam int P_ARE  = 4;

  logic clk = 1'b0;
  logic res = 1'b1;

  pll_lock_monitor_if #(.CNT_W(CW)) bus ();

  pll_lock_monitor #(
    .SYNC_STAGES   (2),
    .QUAL_CYCLES   (QC),
    .HOLDOFF_CYCLES(HC),
    .TIMEOUT_CYCLES(TC),
    .ARESET_CYCLES (AC),
    .CNT_W         (CW)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: phase plus the edge at which it was entered
  int m_pipe0, m_pipe1;
  int m_ph, m_entry, m_n;
  int m_locked, m_are, m_sticky, m_loss, m_retry;

  int ec, last_edge, are_hi;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe0 = 0; m_pipe1 = 0;
    m_ph = P_WAIT; m_entry = 0; m_n = 0;
    m_locked = 0; m_are = 0; m_sticky = 0;
    m_loss = 0; m_retry = 0;
    ec = 0; are_hi = 0;
  endtask

  task automatic model_step(input int lr, input int cl);
    int s, el, nph, le, re;
    s = m_pipe1;
    m_pipe1 = m_pipe0;
    m_pipe0 = lr;
    el = m_n - m_entry;
    nph = m_ph; le = 0; re = 0;
    case (m_ph)
      P_WAIT:
        if (s != 0) nph = P_QUAL;
        else if (el == TC - 1) begin nph = P_ARE; re = 1; end
      P_QUAL:
        if (s == 0) nph = P_WAIT;
        else if (el == QC - 1) nph = P_LOCK;
      P_LOCK:
        if (s == 0) begin nph = P_HOLD; le = 1; end
      P_HOLD:
        if (el == HC - 1) nph = P_WAIT;
      default:
        if (el == AC - 1) nph = P_WAIT;
    endcase
    if (nph != m_ph) begin
      m_ph = nph;
      m_entry = m_n + 1;
    end
    m_n++;
    m_locked = (m_ph == P_LOCK) ? 1 : 0;
    m_are    = (m_ph == P_ARE) ? 1 : 0;
    if (cl != 0) begin
      m_loss = le; m_retry = re; m_sticky = le;
    end else begin
      m_loss  = (m_loss + le > SAT) ? SAT : m_loss + le;
      m_retry = (m_retry + re > SAT) ? SAT : m_retry + re;
      if (le != 0) m_sticky = 1;
    end
  endtask

  task automatic check_all();
    chk("locked", bus.locked, m_locked);
    chk("pll_areset", bus.pll_areset, m_are);
    chk("loss_sticky", bus.loss_sticky, m_sticky);
    chk("loss_count", bus.loss_count, m_loss);
    chk("retry_count", bus.retry_count, m_retry);
  endtask

  task automatic step(input logic lr, input logic cl);
    bus.lock_raw = lr;
    bus.clear = cl;
    @(posedge clk);
    model_step(int'(lr), int'(cl));
    last_edge = ec;
    ec++;
    #1;
    check_all();
    if (bus.pll_areset) are_hi++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1;
    bus.lock_raw = 1'b0;
    bus.clear = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    res = 1'b0;
  endtask

  initial begin
    int rise, lossedge, pulses, prev, first;
    logic val, prev_are;
    int len;

    bus.lock_raw = 1'b0;
    bus.clear = 1'b0;
    model_reset();

    // clean lock
    do_reset();
    rise = -1;
    for (int k = 0; k < 30; k++) begin
      step(k >= 5, 1'b0);
      if (bus.locked && rise < 0) rise = last_edge;
    end
    chk("t1_rise_edge", rise, 15);
    chk("t1_no_areset", are_hi, 0);
    chk("t1_loss0", bus.loss_count, 0);

    // loss and holdoff
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("t3_still_locked", bus.locked, 1);
    step(1'b1, 1'b0);
    lossedge = last_edge;
    chk("t3_unlocked", bus.locked, 0);
    chk("t3_loss1", bus.loss_count, 1);
    chk("t3_sticky", bus.loss_sticky, 1);
    rise = -1;
    for (int k = 0; k < 25; k++) begin
      step(1'b1, 1'b0);
      if (bus.locked && rise < 0) rise = last_edge;
    end
    chk("t3_relock_gap", rise - lossedge, 13);

    // build up to five losses, then clear on a loss edge
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 1'b0);
      repeat (20) step(1'b1, 1'b0);
    end
    chk("t5_loss5", bus.loss_count, 5);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("t5_coll_loss", bus.loss_count, 1);
    chk("t5_coll_sticky", bus.loss_sticky, 1);
    repeat (20) step(1'b1, 1'b0);
    chk("t5_relocked", bus.locked, 1);
    step(1'b1, 1'b1);
    chk("t5_clr_loss", bus.loss_count, 0);
    chk("t5_clr_sticky", bus.loss_sticky, 0);
    chk("t5_clr_locked", bus.locked, 1);

    // glitch during qualify
    do_reset();
    rise = -1;
    for (int k = 0; k < 30; k++) begin
      step(k != 5, 1'b0);
      if (bus.locked && rise < 0) rise = last_edge;
    end
    chk("t2_rise_edge", rise, 16);
    chk("t2_loss0", bus.loss_count, 0);

    // timeout retries until saturation
    do_reset();
    pulses = 0; prev = -1; first = -1;
    prev_are = 1'b0;
    for (int k = 0; k < 16 * (TC + AC) + 10; k++) begin
      step(1'b0, 1'b0);
      if (bus.pll_areset && !prev_are) begin
        if (first < 0) first = last_edge;
        if (prev >= 0) chk("t4_period", last_edge - prev, TC + AC);
        prev = last_edge;
        pulses++;
      end
      prev_are = bus.pll_areset;
    end
    chk("t4_first_pulse", first, TC - 1);
    chk("t4_pulse_width", are_hi, AC * pulses);
    chk("t4_pulses", pulses >= 16, 1);
    chk("t4_retry_sat", bus.retry_count, SAT);

    // reset during second cycle of an areset pulse
    first = -1;
    for (int k = 0; k < TC + AC + 2; k++) begin
      if (first < 0) begin
        step(1'b0, 1'b0);
        if (bus.pll_areset) first = last_edge;
      end
    end
    chk("t6_pulse_found", first >= 0, 1);
    step(1'b0, 1'b0);
    chk("t6_second_cycle", bus.pll_areset, 1);
    #2;
    res = 1'b1;
    #1;
    chk("t6_async_areset", bus.pll_areset, 0);
    chk("t6_async_retry", bus.retry_count, 0);
    model_reset();
    @(negedge clk);
    res = 1'b0;
    repeat (5) step(1'b0, 1'b0);
    chk("t6_retry_after", bus.retry_count, 0);

    // random lock patterns with sporadic clears
    do_reset();
    for (int r = 0; r < 60; r++) begin
      val = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) len = $urandom_range(30, 45);
      else len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++)
        step(val, $urandom_range(0, 31) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
